muldiv32: RTL

Multi-cycle multiply/divide unit that sits beside the single-cycle execute ALU. It takes the same rs/rt operands and handles the operations the ALU cannot finish in one cycle: mult, multu, div and divu. It also owns the HI/LO register pair used by mfhi, mflo, mthi and mtlo. The controller stalls issue while `busy` is high.

---
 rtl/minisys_pkg.sv | 19 +
 rtl/muldiv32.sv | 130 +++++++++++++
 2 files changed

// File: rtl/minisys_pkg.sv
// rtl/minisys_pkg.sv - shared encodings and sizing for the multiply/divide unit
package minisys_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic int md_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/muldiv32.sv
// rtl/muldiv32.sv - multi-cycle mult/multu/div/divu unit owning the HI/LO pair
module muldiv32
  import minisys_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] Read_data_1,
  input  logic [DATA_W-1:0] Read_data_2,
  input  logic              hi_we,
  input  logic              lo_we,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = md_cnt_w(DATA_W);

  md_state_e             r_state, w_state_nxt;
  logic [2*DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]     r_b, r_rs;
  logic                  r_is_div, r_neg_q, r_neg_r, r_div0;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept, w_last, w_a_neg, w_b_neg;
  logic [DATA_W-1:0]     w_a_abs, w_b_abs, w_rem_new, w_quo, w_rem;
  logic [DATA_W:0]       w_add_a, w_add_b;
  logic                  w_cin;
  logic [DATA_W+1:0]     w_sum;
  logic [2*DATA_W-1:0]   w_acc_step, w_prod;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Signed ops work on magnitudes; |most-negative| fits as an unsigned W-bit value.
  assign w_a_neg = ~op[0] & Read_data_1[DATA_W-1];
  assign w_b_neg = ~op[0] & Read_data_2[DATA_W-1];
  assign w_a_abs = w_a_neg ? -Read_data_1 : Read_data_1;
  assign w_b_abs = w_b_neg ? -Read_data_2 : Read_data_2;

  // One W+1-bit adder: shift-add for multiply, trial subtract for restoring divide.
  always_comb begin
    if (r_is_div) begin
      w_add_a = r_acc[2*DATA_W-1:DATA_W-1];
      w_add_b = ~{1'b0, r_b};
      w_cin   = 1'b1;
    end else begin
      w_add_a = {1'b0, r_acc[2*DATA_W-1:DATA_W]};
      w_add_b = r_acc[0] ? {1'b0, r_b} : '0;
      w_cin   = 1'b0;
    end
  end

  assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(DATA_W+1){1'b0}}, w_cin};
  assign w_rem_new = w_sum[DATA_W+1] ? w_sum[DATA_W-1:0] : w_add_a[DATA_W-1:0];
  assign w_acc_step = r_is_div ? {w_rem_new, r_acc[DATA_W-2:0], w_sum[DATA_W+1]}
                               : {w_sum[DATA_W:0], r_acc[DATA_W-1:1]};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_rs     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (r_state == ST_FIX);
      if (w_accept) begin
        r_acc    <= {{DATA_W{1'b0}}, w_a_abs};
        r_b      <= w_b_abs;
        r_rs     <= Read_data_1;
        r_is_div <= op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_div0   <= (Read_data_2 == '0);
        r_cnt    <= '0;
        busy     <= 1'b1;
      end else if (r_state == ST_CALC) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == ST_FIX) begin
        busy <= 1'b0;
        if (!r_is_div) begin
          HI <= w_prod[2*DATA_W-1:DATA_W];
          LO <= w_prod[DATA_W-1:0];
        end else if (r_div0) begin
          HI <= r_rs;
          LO <= '1;
        end else begin
          HI <= w_rem;
          LO <= w_quo;
        end
      end else if (r_state == ST_IDLE) begin
        if (hi_we) HI <= Read_data_1;
        if (lo_we) LO <= Read_data_1;
      end
    end
  end

endmodule
